// File: rtl/mips_cpu_bus_avalon_if.sv
// Avalon-MM bus bundle shared by instruction fetch and data access.
// The CPU side uses the master modport; memory models and interconnect use slave.
interface mips_cpu_bus_avalon_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_bus_avalon.sv
// Multi-cycle MIPS32 integer subset CPU with a single Avalon-MM master port.
// Each instruction walks FETCH -> EXEC -> (MEM -> (WB)) and the CPU parks in
// HALT once control reaches address 0 after a delay slot has completed.
module mips_cpu_bus_avalon #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         active,
  output logic [31:0]                  register_v0,
  mips_cpu_bus_avalon_if.master        bus
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, npc;
  logic [31:0] gpr [32];

  // Memory operation captured in EXEC so MEM/WB no longer depend on readdata.
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_load;
  logic [5:0]  mem_op;
  logic [1:0]  mem_lane;
  logic [4:0]  mem_rt;

  // Instruction fields, decoded straight from readdata during EXEC.
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, br_target;

  assign instr     = bus.readdata;
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  assign rs_val    = gpr[rs];
  assign rt_val    = gpr[rt];
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'd0, imm};
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  assign register_v0 = gpr[2];
  assign active      = !reset || (state != S_HALT);

  // Decode results for the instruction in EXEC.
  logic        alu_wen, jump, mem_go, ld;
  logic [4:0]  alu_dst;
  logic [31:0] alu_res, jump_target, ea, wdata;
  logic [3:0]  be;

  // Decode, ALU, branch resolution and memory-op setup for the EXEC instruction.
  always_comb begin
    alu_wen     = 1'b0;
    alu_dst     = rt;
    alu_res     = 32'd0;
    jump        = 1'b0;
    jump_target = br_target;
    mem_go      = 1'b0;
    ld          = 1'b0;
    be          = 4'b0000;
    wdata       = 32'd0;
    ea          = rs_val + imm_sext;
    case (opcode)
      6'h00: begin
        alu_dst = rd;
        alu_wen = 1'b1;
        case (funct)
          6'h00: alu_res = rt_val << shamt;
          6'h02: alu_res = rt_val >> shamt;
          6'h03: alu_res = $signed(rt_val) >>> shamt;
          6'h04: alu_res = rt_val << rs_val[4:0];
          6'h06: alu_res = rt_val >> rs_val[4:0];
          6'h07: alu_res = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin
            alu_wen     = 1'b0;
            jump        = 1'b1;
            jump_target = rs_val;
          end
          6'h09: begin
            jump        = 1'b1;
            jump_target = rs_val;
            alu_res     = pc + 32'd8;
          end
          6'h21: alu_res = rs_val + rt_val;
          6'h23: alu_res = rs_val - rt_val;
          6'h24: alu_res = rs_val & rt_val;
          6'h25: alu_res = rs_val | rt_val;
          6'h26: alu_res = rs_val ^ rt_val;
          6'h27: alu_res = ~(rs_val | rt_val);
          6'h2A: alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: alu_res = {31'd0, rs_val < rt_val};
          default: alu_wen = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) jump = rs_val[31];
        else if (rt == 5'd1) jump = !rs_val[31];
      end
      6'h02: begin
        jump        = 1'b1;
        jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
      end
      6'h03: begin
        jump        = 1'b1;
        jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
        alu_wen     = 1'b1;
        alu_dst     = 5'd31;
        alu_res     = pc + 32'd8;
      end
      6'h04: jump = (rs_val == rt_val);
      6'h05: jump = (rs_val != rt_val);
      6'h06: jump = rs_val[31] || (rs_val == 32'd0);
      6'h07: jump = !rs_val[31] && (rs_val != 32'd0);
      6'h09: begin alu_wen = 1'b1; alu_res = rs_val + imm_sext; end
      6'h0A: begin alu_wen = 1'b1; alu_res = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
      6'h0B: begin alu_wen = 1'b1; alu_res = {31'd0, rs_val < imm_sext}; end
      6'h0C: begin alu_wen = 1'b1; alu_res = rs_val & imm_zext; end
      6'h0D: begin alu_wen = 1'b1; alu_res = rs_val | imm_zext; end
      6'h0E: begin alu_wen = 1'b1; alu_res = rs_val ^ imm_zext; end
      6'h0F: begin alu_wen = 1'b1; alu_res = {imm, 16'd0}; end
      6'h20, 6'h24: begin
        mem_go = 1'b1;
        ld     = 1'b1;
        be     = 4'b0001 << ea[1:0];
      end
      6'h21, 6'h25: begin
        if (!ea[0]) begin
          mem_go = 1'b1;
          ld     = 1'b1;
          be     = ea[1] ? 4'b1100 : 4'b0011;
        end
      end
      6'h23: begin
        if (ea[1:0] == 2'b00) begin
          mem_go = 1'b1;
          ld     = 1'b1;
          be     = 4'b1111;
        end
      end
      6'h28: begin
        mem_go = 1'b1;
        be     = 4'b0001 << ea[1:0];
        wdata  = {24'd0, rt_val[7:0]} << {ea[1:0], 3'b000};
      end
      6'h29: begin
        if (!ea[0]) begin
          mem_go = 1'b1;
          be     = ea[1] ? 4'b1100 : 4'b0011;
          wdata  = {16'd0, rt_val[15:0]} << {ea[1], 4'b0000};
        end
      end
      6'h2B: begin
        if (ea[1:0] == 2'b00) begin
          mem_go = 1'b1;
          be     = 4'b1111;
          wdata  = rt_val;
        end
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension during WB.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  always_comb begin
    case (mem_lane)
      2'd1:    ld_byte = bus.readdata[15:8];
      2'd2:    ld_byte = bus.readdata[23:16];
      2'd3:    ld_byte = bus.readdata[31:24];
      default: ld_byte = bus.readdata[7:0];
    endcase
    ld_half = mem_lane[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (mem_op)
      6'h20:   load_val = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   load_val = {24'd0, ld_byte};
      6'h21:   load_val = {{16{ld_half[15]}}, ld_half};
      6'h25:   load_val = {16'd0, ld_half};
      default: load_val = bus.readdata;
    endcase
  end

  // Next-state logic and bus outputs; bus strobes stay quiet while reset is held.
  always_comb begin
    state_nxt      = state;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = pc;
    bus.byteenable = 4'b0000;
    bus.writedata  = 32'd0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          bus.read       = 1'b1;
          bus.byteenable = 4'b1111;
          if (!bus.waitrequest) state_nxt = S_EXEC;
        end
        S_EXEC: begin
          if (mem_go)            state_nxt = S_MEM;
          else if (npc == 32'd0) state_nxt = S_HALT;
          else                   state_nxt = S_FETCH;
        end
        S_MEM: begin
          bus.address    = mem_addr;
          bus.byteenable = mem_be;
          if (mem_load) begin
            bus.read = 1'b1;
          end else begin
            bus.write     = 1'b1;
            bus.writedata = mem_wdata;
          end
          if (!bus.waitrequest) begin
            if (mem_load)         state_nxt = S_WB;
            else if (pc == 32'd0) state_nxt = S_HALT;
            else                  state_nxt = S_FETCH;
          end
        end
        S_WB:    state_nxt = (pc == 32'd0) ? S_HALT : S_FETCH;
        default: state_nxt = S_HALT;
      endcase
    end
  end

  // State, program counter pair and captured memory operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_VECTOR;
      npc       <= RESET_VECTOR + 32'd4;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
      mem_load  <= 1'b0;
      mem_op    <= 6'd0;
      mem_lane  <= 2'd0;
      mem_rt    <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) begin
        pc        <= npc;
        npc       <= jump ? jump_target : npc + 32'd4;
        mem_addr  <= {ea[31:2], 2'b00};
        mem_wdata <= wdata;
        mem_be    <= be;
        mem_load  <= ld;
        mem_op    <= opcode;
        mem_lane  <= ea[1:0];
        mem_rt    <= rt;
      end
    end
  end

  // Register file writeback; $0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (state == S_EXEC && alu_wen && alu_dst != 5'd0) begin
      gpr[alu_dst] <= alu_res;
    end else if (state == S_WB && mem_rt != 5'd0) begin
      gpr[mem_rt] <= load_val;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_avalon.sv
// Directed bench for mips_cpu_bus_avalon: a word-addressed memory model sits
// behind the Avalon port and small hand-assembled programs are run to halt.
module tb_mips_cpu_bus_avalon;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;

  mips_cpu_bus_avalon_if bus ();

  mips_cpu_bus_avalon dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Code lives at 0xBFC00000 (indices 256..511), data at 0x000..0x3FF (0..255).
  logic [31:0] mem [512];
  logic [31:0] prog [16];
  logic [31:0] data_img [4];

  int          rd_count, wr_count, strobe_count;
  logic        both_seen;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wbe;
  logic [31:0] fetch_q [$];

  function automatic int unsigned idx(input logic [31:0] a);
    return {23'd0, a[31], a[9:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory slave: reloads its image while reset is held, answers reads one cycle later.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      for (int i = 0; i < 16; i++) mem[256 + i] <= prog[i];
      for (int i = 0; i < 4; i++) mem[64 + i] <= data_img[i];
      bus.readdata <= 32'h0;
      rd_count     <= 0;
      wr_count     <= 0;
      strobe_count <= 0;
      both_seen    <= 1'b0;
      last_waddr   <= 32'h0;
      last_wdata   <= 32'h0;
      last_wbe     <= 4'h0;
      fetch_q.delete();
    end else begin
      if (bus.read || bus.write) strobe_count <= strobe_count + 1;
      if (bus.read && bus.write) both_seen <= 1'b1;
      if (bus.read && !bus.waitrequest) begin
        bus.readdata <= mem[idx(bus.address)];
        rd_count     <= rd_count + 1;
        if (bus.address[31]) fetch_q.push_back(bus.address);
      end
      if (bus.write && !bus.waitrequest) begin
        mem[idx(bus.address)] <= merge(mem[idx(bus.address)], bus.writedata, bus.byteenable);
        wr_count   <= wr_count + 1;
        last_waddr <= bus.address;
        last_wdata <= bus.writedata;
        last_wbe   <= bus.byteenable;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    for (int i = 0; i < 4; i++) data_img[i] = 32'h0;
  endtask

  // Holds reset low for two edges and returns at a falling edge with reset still low.
  task automatic apply_stimulus_reset();
    reset           = 1'b0;
    bus.waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    while (active !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_halted"}, {31'd0, active}, 32'd0);
  endtask

  task automatic run_to_fetch(input logic [31:0] addr, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.read === 1'b1 && bus.address === addr) && n < 400);
    check_output({tag, "_reached"}, {31'd0, bus.read === 1'b1 && bus.address === addr}, 32'd1);
  endtask

  task automatic wait_for_write(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.write !== 1'b1 && n < 400);
    check_output({tag, "_seen"}, {31'd0, bus.write}, 32'd1);
  endtask

  // Directed program sequence.
  initial begin
    int snap;
    int found;
    reset           = 1'b0;
    bus.waitrequest = 1'b0;

    // Program 1: ADDIU $2,$0,5 ; JR $0 ; NOP
    clear_image();
    prog[0] = 32'h24020005;
    prog[1] = 32'h00000008;
    prog[2] = 32'h00000000;
    apply_stimulus_reset();
    check_output("rst_read", {31'd0, bus.read}, 32'd0);
    check_output("rst_write", {31'd0, bus.write}, 32'd0);
    check_output("rst_be", {28'd0, bus.byteenable}, 32'd0);
    check_output("rst_addr", bus.address, 32'hBFC00000);
    check_output("rst_wdata", bus.writedata, 32'h0);
    check_output("rst_active", {31'd0, active}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("boot_read", {31'd0, bus.read}, 32'd1);
    check_output("boot_addr", bus.address, 32'hBFC00000);
    check_output("boot_be", {28'd0, bus.byteenable}, 32'hF);
    check_output("boot_active", {31'd0, active}, 32'd1);
    run_to_halt("p1");
    check_output("p1_v0", register_v0, 32'd5);
    check_output("p1_fetches", fetch_q.size(), 32'd3);
    snap = strobe_count;
    repeat (10) @(negedge clk);
    check_output("p1_idle_bus", strobe_count, snap);
    check_output("p1_idle_active", {31'd0, active}, 32'd0);

    // Program 2: same shape, first fetch stalled for three cycles
    clear_image();
    prog[0] = 32'h24020007;
    prog[1] = 32'h00000008;
    apply_stimulus_reset();
    reset           = 1'b1;
    bus.waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("p2_stall_read%0d", k), {31'd0, bus.read}, 32'd1);
      check_output($sformatf("p2_stall_addr%0d", k), bus.address, 32'hBFC00000);
    end
    check_output("p2_stall_v0", register_v0, 32'd0);
    bus.waitrequest = 1'b0;
    run_to_halt("p2");
    check_output("p2_v0", register_v0, 32'd7);
    check_output("p2_fetches", fetch_q.size(), 32'd3);

    // Program 3: SW then LW of 0xDEADBEEF at 0x100, store stalled
    clear_image();
    prog[0] = 32'h3C02DEAD;  // LUI   $2,0xDEAD
    prog[1] = 32'h3442BEEF;  // ORI   $2,$2,0xBEEF
    prog[2] = 32'h24030100;  // ADDIU $3,$0,0x100
    prog[3] = 32'hAC620000;  // SW    $2,0($3)
    prog[4] = 32'h24020000;  // ADDIU $2,$0,0
    prog[5] = 32'h8C640000;  // LW    $4,0($3)
    prog[6] = 32'h00801021;  // ADDU  $2,$4,$0
    prog[7] = 32'h00000008;  // JR    $0
    apply_stimulus_reset();
    reset = 1'b1;
    wait_for_write("p3_sw");
    bus.waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("p3_hold_addr%0d", k), bus.address, 32'h100);
      check_output($sformatf("p3_hold_wdata%0d", k), bus.writedata, 32'hDEADBEEF);
    end
    check_output("p3_hold_write", {31'd0, bus.write}, 32'd1);
    bus.waitrequest = 1'b0;
    run_to_fetch(32'hBFC00014, "p3_pre_lw");
    check_output("p3_v0_cleared", register_v0, 32'd0);
    run_to_halt("p3");
    check_output("p3_waddr", last_waddr, 32'h100);
    check_output("p3_wdata", last_wdata, 32'hDEADBEEF);
    check_output("p3_wbe", {28'd0, last_wbe}, 32'hF);
    check_output("p3_mem", mem[64], 32'hDEADBEEF);
    check_output("p3_writes", wr_count, 32'd1);
    check_output("p3_v0_lw", register_v0, 32'hDEADBEEF);

    // Program 4: SB into lane 1, LB/LBU of 0x80 from lane 2
    clear_image();
    prog[0] = 32'h24030100;  // ADDIU $3,$0,0x100
    prog[1] = 32'h240200AB;  // ADDIU $2,$0,0xAB
    prog[2] = 32'hA0620001;  // SB    $2,1($3)
    prog[3] = 32'h80650006;  // LB    $5,6($3)
    prog[4] = 32'h90660006;  // LBU   $6,6($3)
    prog[5] = 32'h00A01021;  // ADDU  $2,$5,$0
    prog[6] = 32'h00C01021;  // ADDU  $2,$6,$0
    prog[7] = 32'h00000008;  // JR    $0
    data_img[0] = 32'h11223344;
    data_img[1] = 32'h00800000;
    apply_stimulus_reset();
    reset = 1'b1;
    run_to_fetch(32'hBFC00018, "p4_after_lb");
    check_output("p4_lb", register_v0, 32'hFFFFFF80);
    check_output("p4_sb_addr", last_waddr, 32'h100);
    check_output("p4_sb_be", {28'd0, last_wbe}, 32'h2);
    check_output("p4_sb_lane", {24'd0, last_wdata[15:8]}, 32'hAB);
    check_output("p4_sb_mem", mem[64], 32'h1122AB44);
    run_to_halt("p4");
    check_output("p4_lbu", register_v0, 32'h80);

    // Program 5: BEQ taken, delay slot executes, fall-through skipped
    clear_image();
    prog[0] = 32'h24020001;  // ADDIU $2,$0,1
    prog[1] = 32'h10000002;  // BEQ   $0,$0,+2
    prog[2] = 32'h24420010;  // ADDIU $2,$2,0x10  (delay slot)
    prog[3] = 32'h24420100;  // ADDIU $2,$2,0x100 (skipped)
    prog[4] = 32'h00000008;  // JR    $0
    apply_stimulus_reset();
    reset = 1'b1;
    run_to_halt("p5");
    check_output("p5_v0", register_v0, 32'h11);
    check_output("p5_fetches", fetch_q.size(), 32'd5);
    check_output("p5_target_fetch", (fetch_q.size() > 3) ? fetch_q[3] : 32'h0, 32'hBFC00010);
    found = 0;
    foreach (fetch_q[i]) if (fetch_q[i] == 32'hBFC0000C) found = 1;
    check_output("p5_skip", found, 32'd0);

    // Program 6: SRA, SLT, SLTU, JAL with SUBU in its delay slot
    clear_image();
    prog[0]  = 32'h2403FFF0;  // ADDIU $3,$0,-16
    prog[1]  = 32'h00031083;  // SRA   $2,$3,2
    prog[2]  = 32'h0060102A;  // SLT   $2,$3,$0
    prog[3]  = 32'h0060102B;  // SLTU  $2,$3,$0
    prog[4]  = 32'h0FF00008;  // JAL   0xBFC00020
    prog[5]  = 32'h00031023;  // SUBU  $2,$0,$3  (delay slot)
    prog[6]  = 32'h24020055;  // ADDIU $2,$0,0x55 (skipped)
    prog[8]  = 32'h03E01021;  // ADDU  $2,$31,$0
    prog[9]  = 32'h00000008;  // JR    $0
    apply_stimulus_reset();
    reset = 1'b1;
    run_to_fetch(32'hBFC00008, "p6_sra");
    check_output("p6_sra_v0", register_v0, 32'hFFFFFFFC);
    run_to_fetch(32'hBFC0000C, "p6_slt");
    check_output("p6_slt_v0", register_v0, 32'd1);
    run_to_fetch(32'hBFC00010, "p6_sltu");
    check_output("p6_sltu_v0", register_v0, 32'd0);
    run_to_fetch(32'hBFC00020, "p6_jal");
    check_output("p6_subu_v0", register_v0, 32'h10);
    run_to_halt("p6");
    check_output("p6_link_v0", register_v0, 32'hBFC00018);
    check_output("p6_no_rw_overlap", {31'd0, both_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
